// File: rtl/mem_handshake_bridge.sv
// mem_handshake_bridge: bridges the multicycle CPU memory port to a req/ack external memory.
// Defining MEM_WRITE_BUFFER_EN adds a one-entry posted-write buffer (DRAIN state).
module mem_handshake_bridge #(
   parameter int          TIMEOUT = 255,
   parameter logic [31:0] ERRDATA = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memread,
   input  logic        memwrite,
   input  logic [31:0] adr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        stall,
   output logic        buserr,
   output logic        mreq,
   output logic        mwe,
   output logic [31:0] maddr,
   output logic [31:0] mwdata,
   input  logic [31:0] mrdata,
   input  logic        mack
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DONE  = 2'd2
`ifdef MEM_WRITE_BUFFER_EN
      , DRAIN = 2'd3
`endif
   } state_t;

   // Last counter value before the access is abandoned; mreq stays high TIMEOUT cycles.
   localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

   state_t      state_r;
   state_t      state_nxt_s;
   logic        issue_s;
   logic        ack_s;
   logic        tout_s;
   logic        stall_s;
   logic [7:0]  cnt_r;
   logic        mreq_r;
   logic        mwe_r;
   logic        buserr_r;
   logic [31:0] maddr_r;
   logic [31:0] mwdata_r;
   logic [31:0] readdata_r;

   // Next-state, stall and access-event decode
   always_comb begin
      state_nxt_s = state_r;
      stall_s     = 1'b0;
      issue_s     = 1'b0;
      ack_s       = 1'b0;
      tout_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (memwrite) begin
               issue_s = 1'b1;
`ifdef MEM_WRITE_BUFFER_EN
               stall_s     = 1'b0;
               state_nxt_s = DRAIN;
`else
               stall_s     = 1'b1;
               state_nxt_s = WAIT;
`endif
            end else if (memread) begin
               issue_s     = 1'b1;
               stall_s     = 1'b1;
               state_nxt_s = WAIT;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT: begin
            stall_s = 1'b1;
            if (mack) begin
               ack_s       = 1'b1;
               state_nxt_s = DONE;
            end else if (cnt_r == TLAST) begin
               tout_s      = 1'b1;
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = WAIT;
            end
         end
         DONE: begin
            state_nxt_s = IDLE;
         end
`ifdef MEM_WRITE_BUFFER_EN
         DRAIN: begin
            // A new request must wait for the posted write; it is re-sampled in IDLE.
            stall_s = memread | memwrite;
            if (mack) begin
               ack_s       = 1'b1;
               state_nxt_s = IDLE;
            end else if (cnt_r == TLAST) begin
               tout_s      = 1'b1;
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
`endif
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // External bus, timeout counter and read-result registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mreq_r     <= 1'b0;
         mwe_r      <= 1'b0;
         maddr_r    <= 32'd0;
         mwdata_r   <= 32'd0;
         readdata_r <= 32'd0;
         buserr_r   <= 1'b0;
         cnt_r      <= 8'd0;
      end else if (issue_s) begin
         mreq_r   <= 1'b1;
         mwe_r    <= memwrite;
         maddr_r  <= adr;
         mwdata_r <= writedata;
         cnt_r    <= 8'd0;
      end else if (ack_s) begin
         mreq_r <= 1'b0;
         if (!mwe_r) begin
            readdata_r <= mrdata;
         end
      end else if (tout_s) begin
         mreq_r   <= 1'b0;
         buserr_r <= 1'b1;
         if (!mwe_r) begin
            readdata_r <= ERRDATA;
         end
      end else if (mreq_r) begin
         cnt_r <= cnt_r + 8'd1;
      end
   end

   assign stall    = stall_s & ~reset;
   assign mreq     = mreq_r;
   assign mwe      = mwe_r;
   assign maddr    = maddr_r;
   assign mwdata   = mwdata_r;
   assign readdata = readdata_r;
   assign buserr   = buserr_r;

endmodule

// File: tb/tb_mem_handshake_bridge.sv
// Self-checking bench for mem_handshake_bridge: a transaction queue and memory model
// define what the bus must carry; directed accesses carry hand-computed stall/data targets.
module tb_mem_handshake_bridge;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        memread = 1'b0;
   logic        memwrite = 1'b0;
   logic        memread_b = 1'b0;
   logic [31:0] adr = 32'd0;
   logic [31:0] writedata = 32'd0;
   logic [31:0] mrdata = 32'd0;
   logic        mack = 1'b0;

   logic [31:0] readdata_a, maddr_a, mwdata_a;
   logic        stall_a, buserr_a, mreq_a, mwe_a;
   logic [31:0] readdata_b, maddr_b, mwdata_b;
   logic        stall_b, buserr_b, mreq_b, mwe_b;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   txn_t        expq[$];
   txn_t        cur;
   logic [31:0] mem [logic [31:0]];
   int          ack_delay = 0;
   int          wait_cnt = 0;
   int          rises = 0;
   logic        expect_idle = 1'b0;
   logic        mreq_prev = 1'b0;

`ifdef MEM_WRITE_BUFFER_EN
   localparam int WR_STALL  = 0;
   localparam int RAW_STALL = 3;
`else
   localparam int WR_STALL  = 2;
   localparam int RAW_STALL = 2;
`endif

   mem_handshake_bridge dut_a (
      .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
      .adr(adr), .writedata(writedata), .readdata(readdata_a), .stall(stall_a),
      .buserr(buserr_a), .mreq(mreq_a), .mwe(mwe_a), .maddr(maddr_a),
      .mwdata(mwdata_a), .mrdata(mrdata), .mack(mack)
   );

   mem_handshake_bridge #(.TIMEOUT(4)) dut_b (
      .clk(clk), .reset(reset), .memread(memread_b), .memwrite(1'b0),
      .adr(adr), .writedata(writedata), .readdata(readdata_b), .stall(stall_b),
      .buserr(buserr_b), .mreq(mreq_b), .mwe(mwe_b), .maddr(maddr_b),
      .mwdata(mwdata_b), .mrdata(mrdata), .mack(1'b0)
   );

   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Memory responder: acks ack_delay cycles after mreq is first seen, one-cycle pulse
   always @(posedge clk) begin
      #1;
      if (reset) begin
         mack = 1'b0;
         wait_cnt = 0;
      end else if (mack) begin
         mack = 1'b0;
      end else if (mreq_a) begin
         if (wait_cnt >= ack_delay) begin
            mack = 1'b1;
            wait_cnt = 0;
            if (mwe_a) mem[maddr_a] = mwdata_a;
            else mrdata = mem.exists(maddr_a) ? mem[maddr_a] : 32'd0;
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
   end

   // Compare process: bus contents against the expected transaction order, every cycle
   always @(negedge clk) begin
      if (reset) begin
         mreq_prev = 1'b0;
      end else begin
         if (mreq_a && !mreq_prev) begin
            rises++;
            check_int("expected_txn_pending", expq.size() > 0 ? 1 : 0, 1);
            if (expq.size() > 0) cur = expq.pop_front();
         end
         if (mreq_a) begin
            check32("mwe", {31'd0, mwe_a}, {31'd0, cur.we});
            check32("maddr", maddr_a, cur.addr);
            if (cur.we) check32("mwdata", mwdata_a, cur.wdata);
         end
         if (expect_idle) begin
            check32("idle_mreq", {31'd0, mreq_a}, 32'd0);
            check32("idle_stall", {31'd0, stall_a}, 32'd0);
         end
         check32("buserr_a", {31'd0, buserr_a}, 32'd0);
         mreq_prev = mreq_a;
      end
   end

   task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input int delay, input int exp_stall, input logic [31:0] exp_rd,
                         input string tag);
      txn_t t;
      int   sc;
      bit   done;
      @(posedge clk); #1;
      expect_idle = 1'b0;
      ack_delay = delay;
      t.we = we; t.addr = a; t.wdata = wd;
      expq.push_back(t);
      memwrite = we; memread = ~we; adr = a; writedata = wd;
      sc = 0; done = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk); #1;
         if (stall_a) sc++;
         else begin
            done = 1'b1;
            break;
         end
      end
      check_int({tag, "_completed"}, int'(done), 1);
      check_int({tag, "_stall_cycles"}, sc, exp_stall);
      check32({tag, "_readdata"}, readdata_a, exp_rd);
   endtask

   task automatic go_idle();
      @(posedge clk); #1;
      memread = 1'b0; memwrite = 1'b0;
      for (int c = 0; c < 300 && mreq_a; c++) begin
         @(posedge clk); #1;
      end
      expect_idle = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, sc, mc;
      mem[32'h0]  = 32'h20020005;
      mem[32'h80] = 32'h8C0A0054;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check32("rst_readdata", readdata_a, 32'd0);
      check32("rst_maddr", maddr_a, 32'd0);
      check32("rst_mwdata", mwdata_a, 32'd0);
      check32("rst_mreq_mwe_stall", {29'd0, mreq_a, mwe_a, stall_a}, 32'd0);
      check32("rst_buserr_b", {31'd0, buserr_b}, 32'd0);
      check32("rst_readdata_b", readdata_b, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      expect_idle = 1'b1;

      // Minimum-latency read
      r0 = rises;
      access(1'b0, 32'h0, 32'd0, 0, 2, 32'h20020005, "rd_min");
      check_int("rd_min_rises", rises - r0, 1);
      go_idle();

      // Read with 5 extra cycles of ack latency
      r0 = rises;
      access(1'b0, 32'h80, 32'd0, 5, 7, 32'h8C0A0054, "rd_slow");
      check_int("rd_slow_rises", rises - r0, 1);
      go_idle();

      // Write leaves readdata alone
      access(1'b1, 32'h54, 32'h00000007, 0, WR_STALL, 32'h8C0A0054, "wr");
      go_idle();
      access(1'b0, 32'h54, 32'd0, 2, 4, 32'h00000007, "rd_back");
      go_idle();

      // Store immediately followed by load of the same address
      r0 = rises;
      access(1'b1, 32'h54, 32'h0000ABCD, 0, WR_STALL, 32'h00000007, "sw_raw");
      access(1'b0, 32'h54, 32'd0, 0, RAW_STALL, 32'h0000ABCD, "lw_raw");
      check_int("raw_rises", rises - r0, 2);
      go_idle();

      // Timeout on the TIMEOUT=4 instance, mack never arrives
      @(posedge clk); #1;
      adr = 32'h100; memread_b = 1'b1;
      sc = 0; mc = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk); #1;
         if (mreq_b) mc++;
         if (stall_b) sc++;
         else break;
      end
      check_int("to_stall_cycles", sc, 5);
      check_int("to_mreq_cycles", mc, 4);
      check32("to_readdata", readdata_b, 32'hDEADBEEF);
      check32("to_buserr", {31'd0, buserr_b}, 32'd1);
      @(posedge clk); #1;
      memread_b = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check32("to_buserr_sticky", {31'd0, buserr_b}, 32'd1);
      check32("to_mreq_low", {31'd0, mreq_b}, 32'd0);

      // Reset asserted mid-access
      @(posedge clk); #1;
      expect_idle = 1'b0;
      ack_delay = 1000;
      cur.we = 1'b0; cur.addr = 32'h200; cur.wdata = 32'd0;
      expq.push_back(cur);
      adr = 32'h200; memread = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check32("pre_rst_mreq", {31'd0, mreq_a}, 32'd1);
      reset = 1'b1;
      #1;
      check32("mid_rst_mreq", {31'd0, mreq_a}, 32'd0);
      check32("mid_rst_stall", {31'd0, stall_a}, 32'd0);
      check32("mid_rst_buserr_b", {31'd0, buserr_b}, 32'd0);
      check32("mid_rst_readdata", readdata_a, 32'd0);
      memread = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      expect_idle = 1'b1;
      r0 = rises;
      access(1'b0, 32'h0, 32'd0, 0, 2, 32'h20020005, "rd_after_rst");
      check_int("rd_after_rst_rises", rises - r0, 1);
      go_idle();
      repeat (2) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
